// File: rtl/power_iter_pkg.sv
// Shared types and constants for the power-iteration controller and its normaliser.
package power_iter_pkg;

  typedef enum logic [2:0] {IDLE, INIT, MAC, SCAN, SHIFT, CHECK, FIN} state_t;
  typedef enum logic [1:0] {N_IDLE, N_SCAN, N_SHIFT} norm_phase_t;
  typedef longint acc_t;

  localparam int MAX_SHIFT = 64;

  function automatic logic [63:0] norm_lo(input int nb);
    return 64'd1 << nb;
  endfunction

  function automatic logic [63:0] norm_hi(input int nb);
    return 64'd1 << (nb + 1);
  endfunction

  // Unsigned magnitude, so the most negative accumulator value does not wrap.
  function automatic logic [63:0] abs64(input acc_t x);
    return (x < 0) ? 64'(-x) : 64'(x);
  endfunction

endpackage

// File: rtl/vec_normalizer.sv
// Holds the M*vector row buffer, finds its largest magnitude serially, then scales
// all rows together by powers of two until that magnitude sits in [2^NB, 2^(NB+1)).
module vec_normalizer
  import power_iter_pkg::*;
#(
  parameter int SIZE_N    = 8,
  parameter int NORM_BITS = 12,
  parameter int IDXW      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDXW-1:0]        wr_idx,
  input  logic [63:0]            wr_data,
  input  logic                   start,
  output logic                   scan_done,
  output logic                   zero,
  output logic                   done,
  output logic [SIZE_N-1:0][31:0] vec
);

  localparam logic [IDXW-1:0] LAST = IDXW'(SIZE_N - 1);
  localparam logic [63:0]     LO   = norm_lo(NORM_BITS);
  localparam logic [63:0]     HI   = norm_hi(NORM_BITS);

  norm_phase_t     phase;
  acc_t            row_buf [SIZE_N];
  logic [IDXW-1:0] idx;
  logic [63:0]     max_abs;
  logic [63:0]     scan_max;
  logic [63:0]     live_max;
  logic [6:0]      steps;
  logic            too_big;
  logic            too_small;

  // The shift decision uses the exact magnitude of the current buffer, because halving
  // a tracked maximum is off by one for negative values under floor rounding.
  always_comb begin
    live_max = '0;
    for (int i = 0; i < SIZE_N; i++) begin
      if (abs64(row_buf[i]) > live_max) live_max = abs64(row_buf[i]);
    end
    scan_max  = (abs64(row_buf[idx]) > max_abs) ? abs64(row_buf[idx]) : max_abs;
    too_big   = (live_max >= HI);
    too_small = (live_max < LO);
    scan_done = (phase == N_SCAN) && (idx == LAST);
    zero      = scan_done && (scan_max == '0);
    done      = (phase == N_SHIFT) &&
                ((!too_big && !too_small) || (steps == 7'(MAX_SHIFT)));
    for (int i = 0; i < SIZE_N; i++) vec[i] = row_buf[i][31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= N_IDLE;
      idx     <= '0;
      max_abs <= '0;
      steps   <= '0;
      for (int i = 0; i < SIZE_N; i++) row_buf[i] <= '0;
    end else begin
      if (wr_en) row_buf[wr_idx] <= $signed(wr_data);
      case (phase)
        N_IDLE: begin
          if (start) begin
            phase   <= N_SCAN;
            idx     <= '0;
            max_abs <= '0;
            steps   <= '0;
          end
        end
        N_SCAN: begin
          max_abs <= scan_max;
          idx     <= idx + IDXW'(1);
          if (idx == LAST) phase <= (scan_max == '0) ? N_IDLE : N_SHIFT;
        end
        N_SHIFT: begin
          if (done) begin
            phase <= N_IDLE;
          end else begin
            steps <= steps + 7'd1;
            for (int i = 0; i < SIZE_N; i++)
              row_buf[i] <= too_big ? (row_buf[i] >>> 1) : (row_buf[i] <<< 1);
          end
        end
        default: phase <= N_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/power_iteration_ctrl.sv
// Power-iteration loop controller: serial MAC of M*vector, power-of-two normalisation
// and the handshake with the downstream convergence checker.
module power_iteration_ctrl
  import power_iter_pkg::*;
#(
  parameter int SIZE_N      = 8,
  parameter int MAX_ITER    = 100,
  parameter int NORM_BITS   = 12,
  parameter int CHK_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [SIZE_N-1:0][SIZE_N-1:0][31:0] mat,
  input  logic                               calculated,
  input  logic                               converged,
  output logic [SIZE_N-1:0][31:0]            vector,
  output logic [SIZE_N-1:0][31:0]            next_vector,
  output logic [31:0]                        count_k,
  output logic                               busy,
  output logic                               done,
  output logic                               conv_ok,
  output logic                               err
);

  localparam int              IDXW     = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
  localparam int              CNTW     = $clog2(CHK_TIMEOUT + 1);
  localparam logic [IDXW-1:0] LAST     = IDXW'(SIZE_N - 1);
  localparam logic [31:0]     INIT_VAL = 32'(norm_lo(NORM_BITS));

  state_t                   state, next_state;
  logic [IDXW-1:0]          r, c;
  acc_t                     acc, prod, mac_sum;
  logic                     mac_drain;
  logic                     mac_step;
  logic                     wr_en;
  logic [63:0]              wr_data;
  logic                     norm_start;
  logic                     norm_scan_done;
  logic                     norm_zero;
  logic                     norm_done;
  logic [SIZE_N-1:0][31:0]  norm_vec;
  logic [CNTW-1:0]          chk_cnt;
  logic                     chk_timeout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A checker answer in the timeout cycle takes priority over the timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = INIT;
      INIT:  next_state = MAC;
      MAC:   if (mac_drain) next_state = SCAN;
      SCAN:  if (norm_scan_done) next_state = norm_zero ? FIN : SHIFT;
      SHIFT: if (norm_done) next_state = CHECK;
      CHECK: begin
        if (calculated) begin
          if (converged || (count_k == 32'(MAX_ITER))) next_state = FIN;
          else                                          next_state = MAC;
        end else if (chk_timeout) begin
          next_state = FIN;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == FIN);
    mac_step    = (state == MAC) && !mac_drain;
    wr_en       = mac_step && (c == LAST);
    norm_start  = (state == MAC) && mac_drain;
    chk_timeout = (state == CHECK) && (chk_cnt == CNTW'(CHK_TIMEOUT));
  end

  always_comb begin
    prod    = acc_t'($signed(mat[r][c])) * acc_t'($signed(vector[c]));
    mac_sum = acc + prod;
    wr_data = 64'(mac_sum);
  end

  // The vectors only move outside CHECK so the checker always sees a stable pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      vector      <= '0;
      next_vector <= '0;
      count_k     <= '0;
      conv_ok     <= 1'b0;
      err         <= 1'b0;
      r           <= '0;
      c           <= '0;
      acc         <= '0;
      mac_drain   <= 1'b0;
      chk_cnt     <= '0;
    end else begin
      if (state != MAC) begin
        r         <= '0;
        c         <= '0;
        acc       <= '0;
        mac_drain <= 1'b0;
      end else if (!mac_drain) begin
        if (c == LAST) begin
          c   <= '0;
          acc <= '0;
          r   <= r + IDXW'(1);
          if (r == LAST) mac_drain <= 1'b1;
        end else begin
          c   <= c + IDXW'(1);
          acc <= mac_sum;
        end
      end
      chk_cnt <= (state == CHECK) ? chk_cnt + CNTW'(1) : '0;
      case (state)
        IDLE: begin
          if (start) begin
            count_k <= '0;
            conv_ok <= 1'b0;
            err     <= 1'b0;
          end
        end
        INIT: begin
          for (int i = 0; i < SIZE_N; i++) vector[i] <= INIT_VAL;
          next_vector <= '0;
        end
        SCAN: if (norm_scan_done && norm_zero) err <= 1'b1;
        SHIFT: begin
          if (norm_done) begin
            next_vector <= norm_vec;
            count_k     <= count_k + 32'd1;
          end
        end
        CHECK: begin
          if (calculated) begin
            if (converged)                         conv_ok <= 1'b1;
            else if (count_k != 32'(MAX_ITER))     vector  <= next_vector;
          end else if (chk_timeout) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  vec_normalizer #(
    .SIZE_N    (SIZE_N),
    .NORM_BITS (NORM_BITS),
    .IDXW      (IDXW)
  ) u_norm (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (r),
    .wr_data   (wr_data),
    .start     (norm_start),
    .scan_done (norm_scan_done),
    .zero      (norm_zero),
    .done      (norm_done),
    .vec       (norm_vec)
  );

endmodule
